ctrl_stack_unit: RTL and testbench

Parametrised call/enable control-stack unit for the next-generation multi-cycle processor core. Holds the return-address stack and the predication enable stack, and executes one control-stack operation per accepted request. Call depth, enable depth and word width are parameters; overflow and underflow are detected instead of silently wrapping. The FSM issues a request in its call/ret/jumpf/enable states and consumes the registered results one cycle later.

---
 rtl/ctrl_stack_pkg.sv | 20 ++
 rtl/ctrl_stack_unit_if.sv | 38 +++
 rtl/lifo_stack.sv | 57 +++++
 rtl/ctrl_stack_unit.sv | 153 +++++++++++++++
 tb/tb_ctrl_stack_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_stack_pkg.sv
// Shared definitions for the control-stack unit.
// Provides the 3-bit opcode encodings and the helper that sizes the
// occupancy counters: a stack of N entries needs to count 0..N inclusive.
package ctrl_stack_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CALL   = 3'd1;
  localparam logic [2:0] OP_RET    = 3'd2;
  localparam logic [2:0] OP_ALLEN  = 3'd3;
  localparam logic [2:0] OP_POPEN  = 3'd4;
  localparam logic [2:0] OP_PUSHEN = 3'd5;
  localparam logic [2:0] OP_JUMPF  = 3'd6;
  localparam logic [2:0] OP_CLRERR = 3'd7;

  // Width of a counter holding 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ctrl_stack_unit_if.sv
// Request/result bundle of the control-stack unit.
// master: requester (drives op_valid, op, cond_in, ret_addr_in).
// slave : the unit (drives op_ready, enabled, ret_addr_out, the three pulses,
//         call_count, en_count, overflow, underflow).
interface ctrl_stack_unit_if import ctrl_stack_pkg::*; #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned CALL_DEPTH = 4,
  parameter int unsigned EN_DEPTH   = 32
) ();

  logic                          op_valid;
  logic                          op_ready;
  logic [2:0]                    op;
  logic [WORD_W-1:0]             cond_in;
  logic [WORD_W-1:0]             ret_addr_in;
  logic                          enabled;
  logic [WORD_W-1:0]             ret_addr_out;
  logic                          call_taken;
  logic                          ret_taken;
  logic                          jump_taken;
  logic [cnt_w(CALL_DEPTH)-1:0]  call_count;
  logic [cnt_w(EN_DEPTH)-1:0]    en_count;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output op_valid, op, cond_in, ret_addr_in,
    input  op_ready, enabled, ret_addr_out, call_taken, ret_taken, jump_taken,
    input  call_count, en_count, overflow, underflow
  );

  modport slave (
    input  op_valid, op, cond_in, ret_addr_in,
    output op_ready, enabled, ret_addr_out, call_taken, ret_taken, jump_taken,
    output call_count, en_count, overflow, underflow
  );

endinterface

// File: rtl/lifo_stack.sv
// Synchronous LIFO used as the return-address stack.
// Ports: i_clk, i_rst (async, active high), i_push/i_data write a new top,
// i_pop registers the current top onto o_pop_data. o_count is the live entry
// count, o_full/o_empty are decoded from it. Push is ignored when full and pop
// when empty; the caller is expected not to request both at once.
module lifo_stack import ctrl_stack_pkg::*; #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [W-1:0]              i_data,
  output logic [W-1:0]              o_pop_data,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_pop_data;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !i_push && !o_empty;

  // Storage is not reset; only the count decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[AW'(r_count)] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count    <= '0;
      r_pop_data <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + CW'(1);
    end else if (w_do_pop) begin
      r_count    <= r_count - CW'(1);
      r_pop_data <= r_mem[AW'(r_count - CW'(1))];
    end
  end

  assign o_pop_data = r_pop_data;
  assign o_count    = r_count;

endmodule

// File: rtl/ctrl_stack_unit.sv
// Call/enable control-stack unit.
// Ports: i_clk, i_rst (async, active high), bus (ctrl_stack_unit_if.slave).
// One request is executed per accepted cycle (op_valid && op_ready, or any
// CLRERR). All results are registered; the pulses last one cycle. The enable
// stack keeps its top in bit 0: PUSHEN shifts left duplicating the top,
// POPEN shifts right filling the MSB with 0. Sticky overflow/underflow block
// every request except CLRERR.
module ctrl_stack_unit import ctrl_stack_pkg::*; #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned CALL_DEPTH = 4,
  parameter int unsigned EN_DEPTH   = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  ctrl_stack_unit_if.slave bus
);

  localparam int unsigned   CW     = cnt_w(CALL_DEPTH);
  localparam int unsigned   EW     = cnt_w(EN_DEPTH);
  localparam logic [EW-1:0] EnFull = EW'(EN_DEPTH);

  logic [EN_DEPTH-1:0] r_en_stack, w_en_stack_nxt;
  logic [EW-1:0]       r_en_count, w_en_count_nxt;
  logic                r_overflow, w_overflow_nxt;
  logic                r_underflow, w_underflow_nxt;
  logic                r_call_taken, w_call_taken_nxt;
  logic                r_ret_taken, w_ret_taken_nxt;
  logic                r_jump_taken, w_jump_taken_nxt;
  logic                w_ready, w_accept, w_enabled;
  logic                w_push, w_pop;
  logic                w_call_full, w_call_empty;
  logic [CW-1:0]       w_call_count;
  logic [WORD_W-1:0]   w_pop_data;

  assign w_ready   = !(r_overflow || r_underflow);
  assign w_accept  = bus.op_valid && (w_ready || (bus.op == OP_CLRERR));
  assign w_enabled = r_en_stack[0];

  always_comb begin
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_en_stack_nxt   = r_en_stack;
    w_en_count_nxt   = r_en_count;
    w_overflow_nxt   = r_overflow;
    w_underflow_nxt  = r_underflow;
    w_call_taken_nxt = 1'b0;
    w_ret_taken_nxt  = 1'b0;
    w_jump_taken_nxt = 1'b0;
    if (w_accept) begin
      unique case (bus.op)
        OP_CALL: begin
          if (w_enabled) begin
            if (w_call_full) begin
              w_overflow_nxt = 1'b1;
            end else begin
              w_push           = 1'b1;
              w_call_taken_nxt = 1'b1;
            end
          end
        end
        OP_RET: begin
          if (w_enabled) begin
            if (w_call_empty) begin
              w_underflow_nxt = 1'b1;
            end else begin
              w_pop           = 1'b1;
              w_ret_taken_nxt = 1'b1;
            end
          end
        end
        OP_ALLEN: w_en_stack_nxt[0] = 1'b1;
        OP_PUSHEN: begin
          if (r_en_count < EnFull) begin
            w_en_stack_nxt = {r_en_stack[EN_DEPTH-2:0], r_en_stack[0]};
            w_en_count_nxt = r_en_count + EW'(1);
          end else begin
            w_overflow_nxt = 1'b1;
          end
        end
        OP_POPEN: begin
          // The base entry is never popped.
          if (r_en_count > EW'(1)) begin
            w_en_stack_nxt = {1'b0, r_en_stack[EN_DEPTH-1:1]};
            w_en_count_nxt = r_en_count - EW'(1);
          end else begin
            w_underflow_nxt = 1'b1;
          end
        end
        OP_JUMPF: begin
          // Branch is reported from the top bit as it is after the clear.
          if (bus.cond_in == '0) begin
            w_en_stack_nxt[0] = 1'b0;
            w_jump_taken_nxt  = 1'b1;
          end else begin
            w_jump_taken_nxt = !r_en_stack[0];
          end
        end
        OP_CLRERR: begin
          w_overflow_nxt  = 1'b0;
          w_underflow_nxt = 1'b0;
        end
        default: ; // OP_NOP
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en_stack   <= EN_DEPTH'(1);
      r_en_count   <= EW'(1);
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_call_taken <= 1'b0;
      r_ret_taken  <= 1'b0;
      r_jump_taken <= 1'b0;
    end else begin
      r_en_stack   <= w_en_stack_nxt;
      r_en_count   <= w_en_count_nxt;
      r_overflow   <= w_overflow_nxt;
      r_underflow  <= w_underflow_nxt;
      r_call_taken <= w_call_taken_nxt;
      r_ret_taken  <= w_ret_taken_nxt;
      r_jump_taken <= w_jump_taken_nxt;
    end
  end

  lifo_stack #(
    .W     (WORD_W),
    .DEPTH (CALL_DEPTH)
  ) u_call_stack (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_data     (bus.ret_addr_in),
    .o_pop_data (w_pop_data),
    .o_count    (w_call_count),
    .o_full     (w_call_full),
    .o_empty    (w_call_empty)
  );

  assign bus.op_ready     = w_ready;
  assign bus.enabled      = w_enabled;
  assign bus.ret_addr_out = w_pop_data;
  assign bus.call_taken   = r_call_taken;
  assign bus.ret_taken    = r_ret_taken;
  assign bus.jump_taken   = r_jump_taken;
  assign bus.call_count   = w_call_count;
  assign bus.en_count     = r_en_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_ctrl_stack_unit.sv
// Directed bench for ctrl_stack_unit. A behavioural model (queues for both
// stacks) predicts every output when a request is driven; the prediction is
// queued and popped for comparison one cycle later.
module tb_ctrl_stack_unit;
  import ctrl_stack_pkg::*;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned CALL_DEPTH = 4;
  localparam int unsigned EN_DEPTH   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_stack_unit_if #(
    .WORD_W     (WORD_W),
    .CALL_DEPTH (CALL_DEPTH),
    .EN_DEPTH   (EN_DEPTH)
  ) bus ();

  ctrl_stack_unit #(
    .WORD_W     (WORD_W),
    .CALL_DEPTH (CALL_DEPTH),
    .EN_DEPTH   (EN_DEPTH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] ready;
    logic [31:0] enabled;
    logic [31:0] ret_addr;
    logic [31:0] call_t;
    logic [31:0] ret_t;
    logic [31:0] jump_t;
    logic [31:0] call_cnt;
    logic [31:0] en_cnt;
    logic [31:0] ovf;
    logic [31:0] unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [WORD_W-1:0] m_call[$];
  bit                m_en[$];   // m_en[0] is the top
  bit                m_ovf, m_unf, m_call_t, m_ret_t, m_jump_t;
  logic [WORD_W-1:0] m_ret;

  task automatic model_reset();
    m_call.delete();
    m_en.delete();
    m_en.push_back(1'b1);
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_call_t = 1'b0;
    m_ret_t  = 1'b0;
    m_jump_t = 1'b0;
    m_ret    = '0;
  endtask

  task automatic model_step(input bit valid, input logic [2:0] op,
                            input logic [WORD_W-1:0] cond, input logic [WORD_W-1:0] ra);
    m_call_t = 1'b0;
    m_ret_t  = 1'b0;
    m_jump_t = 1'b0;
    if (!valid) return;
    if ((m_ovf || m_unf) && op != OP_CLRERR) return;
    case (op)
      OP_CALL: if (m_en[0]) begin
        if (m_call.size() >= CALL_DEPTH) m_ovf = 1'b1;
        else begin m_call.push_back(ra); m_call_t = 1'b1; end
      end
      OP_RET: if (m_en[0]) begin
        if (m_call.size() == 0) m_unf = 1'b1;
        else begin m_ret = m_call.pop_back(); m_ret_t = 1'b1; end
      end
      OP_ALLEN:  m_en[0] = 1'b1;
      OP_PUSHEN: if (m_en.size() < EN_DEPTH) m_en.push_front(m_en[0]); else m_ovf = 1'b1;
      OP_POPEN:  if (m_en.size() > 1) void'(m_en.pop_front()); else m_unf = 1'b1;
      OP_JUMPF: begin
        if (cond == 0) m_en[0] = 1'b0;
        m_jump_t = !m_en[0];
      end
      OP_CLRERR: begin m_ovf = 1'b0; m_unf = 1'b0; end
      default: ;
    endcase
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.ready    = 32'(!(m_ovf || m_unf));
    e.enabled  = 32'(m_en[0]);
    e.ret_addr = 32'(m_ret);
    e.call_t   = 32'(m_call_t);
    e.ret_t    = 32'(m_ret_t);
    e.jump_t   = 32'(m_jump_t);
    e.call_cnt = 32'(m_call.size());
    e.en_cnt   = 32'(m_en.size());
    e.ovf      = 32'(m_ovf);
    e.unf      = 32'(m_unf);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed none expected one entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".op_ready"},     32'(bus.op_ready),     e.ready);
    chk({tag, ".enabled"},      32'(bus.enabled),      e.enabled);
    chk({tag, ".ret_addr_out"}, 32'(bus.ret_addr_out), e.ret_addr);
    chk({tag, ".call_taken"},   32'(bus.call_taken),   e.call_t);
    chk({tag, ".ret_taken"},    32'(bus.ret_taken),    e.ret_t);
    chk({tag, ".jump_taken"},   32'(bus.jump_taken),   e.jump_t);
    chk({tag, ".call_count"},   32'(bus.call_count),   e.call_cnt);
    chk({tag, ".en_count"},     32'(bus.en_count),     e.en_cnt);
    chk({tag, ".overflow"},     32'(bus.overflow),     e.ovf);
    chk({tag, ".underflow"},    32'(bus.underflow),    e.unf);
  endtask

  // Drive one cycle (valid or idle), predict, then compare after the edge.
  task automatic step(input string tag, input bit valid, input logic [2:0] op,
                      input logic [WORD_W-1:0] cond, input logic [WORD_W-1:0] ra);
    bus.op_valid    = valid;
    bus.op          = op;
    bus.cond_in     = cond;
    bus.ret_addr_in = ra;
    model_step(valid, op, cond, ra);
    sb_q.push_back(snapshot());
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [WORD_W-1:0] cond, input logic [WORD_W-1:0] ra);
    step(tag, 1'b1, op, cond, ra);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.op_valid    = 1'b0;
    bus.op          = OP_NOP;
    bus.cond_in     = '0;
    bus.ret_addr_in = '0;
    model_reset();
    #12;
    sb_q.push_back(snapshot());
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic call/return
    do_op("call42", OP_CALL, 16'h0001, 16'h0042);
    do_op("ret42",  OP_RET,  16'h0001, 16'h0000);
    step("idle0", 1'b0, OP_CALL, 16'h0001, 16'h0099);

    // Fill the call stack, overflow, held-off request, clear, drain in order
    for (int i = 0; i < 4; i++) do_op("call_fill", OP_CALL, 16'h0001, 16'(16'h0010 + i));
    do_op("call_ovf",  OP_CALL,   16'h0001, 16'h0014);
    do_op("ret_held",  OP_RET,    16'h0001, 16'h0000);
    do_op("clrerr1",   OP_CLRERR, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) do_op("ret_drain", OP_RET, 16'h0001, 16'h0000);

    // Underflow cases
    do_op("ret_empty", OP_RET,    16'h0001, 16'h0000);
    do_op("clrerr2",   OP_CLRERR, 16'h0000, 16'h0000);
    do_op("popen_base", OP_POPEN, 16'h0001, 16'h0000);
    do_op("clrerr3",   OP_CLRERR, 16'h0000, 16'h0000);

    // Predication
    do_op("pushen1",   OP_PUSHEN, 16'h0001, 16'h0000);
    do_op("jumpf0",    OP_JUMPF,  16'h0000, 16'h0000);
    do_op("call_dis",  OP_CALL,   16'h0001, 16'h0020);
    do_op("ret_dis",   OP_RET,    16'h0001, 16'h0000);
    do_op("popen1",    OP_POPEN,  16'h0001, 16'h0000);
    do_op("jumpf5",    OP_JUMPF,  16'h0005, 16'h0000);
    do_op("jumpf0b",   OP_JUMPF,  16'h0000, 16'h0000);
    do_op("jumpf5dis", OP_JUMPF,  16'h0005, 16'h0000);
    do_op("allen",     OP_ALLEN,  16'h0001, 16'h0000);
    do_op("nop",       OP_NOP,    16'h0000, 16'h0000);

    // Enable stack to full, overflow, clear, then back down to 5 entries
    do_op("jumpf0c",   OP_JUMPF,  16'h0000, 16'h0000);
    for (int i = 0; i < 31; i++) do_op("pushen_fill", OP_PUSHEN, 16'h0001, 16'h0000);
    do_op("pushen_ovf", OP_PUSHEN, 16'h0001, 16'h0000);
    do_op("clrerr4",   OP_CLRERR, 16'h0000, 16'h0000);
    do_op("allen2",    OP_ALLEN,  16'h0001, 16'h0000);
    for (int i = 0; i < 27; i++) do_op("popen_drain", OP_POPEN, 16'h0001, 16'h0000);
    for (int i = 0; i < 3; i++) do_op("call_pre_rst", OP_CALL, 16'h0001, 16'(16'h0030 + i));
    do_op("ret_pre_rst", OP_RET, 16'h0001, 16'h0000);
    do_op("call_pre_rst2", OP_CALL, 16'h0001, 16'h0033);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    sb_q.push_back(snapshot());
    check_outputs("async_rst");
    #1;
    rst = 1'b0;
    do_op("call_post_rst", OP_CALL, 16'h0001, 16'h0077);
    do_op("ret_post_rst",  OP_RET,  16'h0001, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
